// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and default sizes for the game round controller.
package game_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, PLAY = 2'd2, DONE = 2'd3} state_e;
    localparam int SCORE_W_DEF   = 8;
    localparam int ROUND_SECONDS = 30;
endpackage

// File: rtl/game_round_controller_sync_2ff.sv
// sync_2ff: generic two-flop synchroniser, async active-low reset to 0.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q;
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            meta_q <= '0;
            q_o    <= '0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
endmodule

// File: rtl/game_round_controller.sv
// game_round_controller: arms the countdown timer, counts hits during the round, freezes score on finish.
// Optional best-score tracking is built when GAME_ROUND_HIGH_SCORE_EN is defined.
module game_round_controller
    import game_pkg::*;
#(
    parameter int SCORE_W    = SCORE_W_DEF,
    parameter int ARM_CYCLES = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_i,
    input  logic               hit_i,
    input  logic               timer_finish_i,
    output logic               timer_rst_n_o,
    output logic               playing_o,
    output logic               game_over_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [SCORE_W-1:0] high_score_o,
    output logic               new_record_o
);
    localparam int AW = $clog2(ARM_CYCLES);
    localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CYCLES - 1);

    state_e             state_q;
    logic [AW-1:0]      arm_cnt_q;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               start_q, start_rise, fin_s;
    logic               timer_rst_n_q, playing_q, game_over_q;

    sync_2ff #(.W(1)) u_fin_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (timer_finish_i),
        .q_o   (fin_s)
    );

    assign start_rise = start_i & ~start_q;
    assign score_d    = (score_q == '1) ? score_q : score_q + 1'b1;

    // start_q resets high so a button held through reset is not taken as a press
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state_q       <= IDLE;
            arm_cnt_q     <= '0;
            score_q       <= '0;
            start_q       <= 1'b1;
            timer_rst_n_q <= 1'b0;
            playing_q     <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            start_q <= start_i;
            case (state_q)
                IDLE:
                    if (start_rise) begin
                        state_q   <= ARM;
                        arm_cnt_q <= '0;
                        score_q   <= '0;
                    end
                ARM:
                    if (arm_cnt_q != ARM_LAST) arm_cnt_q <= arm_cnt_q + 1'b1;
                    else if (!fin_s) begin
                        state_q       <= PLAY;
                        timer_rst_n_q <= 1'b1;
                        playing_q     <= 1'b1;
                    end
                PLAY:
                    if (fin_s) begin
                        state_q     <= DONE;
                        playing_q   <= 1'b0;
                        game_over_q <= 1'b1;
                    end else if (hit_i) score_q <= score_d;
                DONE:
                    if (start_rise) begin
                        state_q       <= ARM;
                        arm_cnt_q     <= '0;
                        score_q       <= '0;
                        timer_rst_n_q <= 1'b0;
                        game_over_q   <= 1'b0;
                    end
            endcase
        end

    assign timer_rst_n_o = timer_rst_n_q;
    assign playing_o     = playing_q;
    assign game_over_o   = game_over_q;
    assign score_o       = score_q;

`ifdef GAME_ROUND_HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_q;
    logic               rec_q;
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            high_q <= '0;
            rec_q  <= 1'b0;
        end else if (state_q == PLAY && fin_s && score_q > high_q) begin
            high_q <= score_q;
            rec_q  <= 1'b1;
        end else if (state_q == DONE && start_rise) rec_q <= 1'b0;
    assign high_score_o = high_q;
    assign new_record_o = rec_q;
`else
    assign high_score_o = '0;
    assign new_record_o = 1'b0;
`endif
endmodule
